// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline sequencing controller for a 5-stage RV32I core (IF/ID/EX/MEM/WB).
//   - Decodes rs1/rs2 usage of the ID-stage instruction and detects load-use
//     hazards against the load currently in EX (one bubble per hazard).
//   - Flushes IF/ID and ID/EX on a taken branch/jump resolved in EX.
//   - Hands EX off to a multi-cycle unit (mul/div): issues a start pulse,
//     freezes the front end until mc_done, and aborts after MC_TIMEOUT cycles
//     with a sticky error flag.
//
// Build option:
//   PIPE_HAZARD_PERF_EN  when defined, builds 32-bit wrapping counters for
//                        stall cycles (stall_f=1) and branch flushes. When not
//                        defined, stall_cnt/flush_cnt are tied to zero.
//
// Parameters:
//   MC_TIMEOUT  maximum cycles spent in MC_WAIT before a forced abort (>=2)
//   REG_AW      register address width
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high
//   id_instr     instruction currently in ID
//   ex_rd        destination register of the EX instruction
//   ex_mem_read  EX instruction is a load
//   ex_mc_req    EX instruction needs the multi-cycle unit
//   br_taken     EX resolved a taken branch/JAL/JALR
//   mc_done      multi-cycle result valid (1-cycle pulse)
//   stall_f/d/e  hold PC, IF/ID, ID/EX
//   flush_d/e/m  bubble IF/ID, ID/EX, EX/MEM
//   mc_start     1-cycle start pulse to the multi-cycle unit
//   mc_err       sticky timeout flag (cleared only by rst)
//   busy         controller is waiting on the multi-cycle unit
//   stall_cnt    stall-cycle count
//   flush_cnt    branch-flush count
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_instr,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mc_req,
  input  logic              br_taken,
  input  logic              mc_done,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              mc_start,
  output logic              mc_err,
  output logic              busy,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MC_TIMEOUT - 1);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_WAIT = 1'b1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_nxt;
  logic              err_set;
  logic              use1;
  logic              use2;
  logic              lu_hz;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              unused_instr_bits;

  assign rs1 = REG_AW'(id_instr[19:15]);
  assign rs2 = REG_AW'(id_instr[24:20]);
  // Fields not needed for hazard detection.
  assign unused_instr_bits = &{1'b0, id_instr[31:25], id_instr[14:7]};

  // Source-register usage decode from the ID opcode.
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (id_instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        use1 = 1'b1;
      end
      OP_STORE, OP_BRANCH, OP_REG: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      default: begin
        // LUI, AUIPC, JAL and unknown opcodes read no registers.
        use1 = 1'b0;
        use2 = 1'b0;
      end
    endcase
  end

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign lu_hz = ex_mem_read && (ex_rd != '0) &&
                 ((use1 && (rs1 == ex_rd)) || (use2 && (rs2 == ex_rd)));

  assign busy = (state == ST_MC_WAIT);

  // Next-state, timer and pipeline control decode.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    mc_start  = 1'b0;
    err_set   = 1'b0;
    state_nxt = state;
    timer_nxt = timer;
    if (rst) begin
      // Everything quiet while in reset; the registers reload RUN regardless.
      state_nxt = ST_RUN;
      timer_nxt = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ex_mc_req) begin
            // Multi-cycle handoff outranks branch and load-use handling.
            mc_start  = 1'b1;
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            stall_e   = 1'b1;
            flush_m   = 1'b1;
            state_nxt = ST_MC_WAIT;
            timer_nxt = '0;
          end else if (br_taken) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (lu_hz) begin
            // Load advances next cycle, so a single bubble resolves it.
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_MC_WAIT: begin
          if (mc_done) begin
            // Done wins over a coincident timeout: release, no error.
            state_nxt = ST_RUN;
          end else if (timer == TIMER_LAST) begin
            state_nxt = ST_RUN;
            err_set   = 1'b1;
          end else begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            stall_e   = 1'b1;
            flush_m   = 1'b1;
            timer_nxt = timer + TW'(1);
          end
        end
        default: begin
          state_nxt = ST_RUN;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // State, watchdog timer and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      timer  <= '0;
      mc_err <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (err_set) begin
        mc_err <= 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  // Performance counters; flush_d is asserted only by the branch flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (stall_f) begin
        stall_count <= stall_count + 32'd1;
      end
      if (flush_d) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_count;
  assign flush_cnt = flush_count;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl (MC_TIMEOUT=8). Each stimulus cycle
// pushes its hand-computed expected outputs into a queue; an independent
// monitor pops one entry per cycle on the falling edge and compares.
// Output vector bit order:
//   {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_start, mc_err, busy}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] NONE = 9'b000_000_000;
  localparam logic [8:0] LU   = 9'b110_010_000;
  localparam logic [8:0] BR   = 9'b000_110_000;
  localparam logic [8:0] MCS  = 9'b111_001_100;
  localparam logic [8:0] MCW  = 9'b111_001_001;
  localparam logic [8:0] BSY  = 9'b000_000_001;
  localparam logic [8:0] ERR  = 9'b000_000_010;

  // add x6,x5,x1 / add x6,x0,x1 / lui x5,0x1 / sw x5,0(x2) / jal x0 with rs1 field=5
  localparam logic [31:0] ADD_655 = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] ADD_601 = {7'd0, 5'd1, 5'd0, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] LUI_5   = {20'h00001, 5'd5, 7'b0110111};
  localparam logic [31:0] SW_5    = {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, 7'b0100011};
  localparam logic [31:0] JAL_F5  = {12'h000, 5'd5, 3'd0, 5'd0, 7'b1101111};

  typedef struct {
    logic [8:0]  v;
    logic [31:0] sc;
    logic [31:0] fc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic [4:0]  ex_rd;
  logic        ex_mem_read, ex_mc_req, br_taken, mc_done;
  logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
  logic        mc_start, mc_err, busy;
  logic [31:0] stall_cnt, flush_cnt;

  exp_t        q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int unsigned m_sc = 0;
  int unsigned m_fc = 0;

  pipe_hazard_ctrl #(.MC_TIMEOUT(8), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mc_req(ex_mc_req), .br_taken(br_taken),
    .mc_done(mc_done), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .mc_start(mc_start), .mc_err(mc_err), .busy(busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs and queue its expected outputs.
  task automatic step(input logic r, input logic [31:0] instr, input logic [4:0] rd,
                      input logic mr, input logic mcr, input logic br, input logic dn,
                      input logic [8:0] ev, input string nm);
    exp_t e;
    rst = r; id_instr = instr; ex_rd = rd;
    ex_mem_read = mr; ex_mc_req = mcr; br_taken = br; mc_done = dn;
    e.v = ev;
`ifdef PIPE_HAZARD_PERF_EN
    e.sc = m_sc;
    e.fc = m_fc;
`else
    e.sc = 32'd0;
    e.fc = 32'd0;
`endif
    e.name = nm;
    q.push_back(e);
    if (r) begin
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (ev[8]) m_sc = m_sc + 1;
      if (ev[5]) m_fc = m_fc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e = q.pop_front();
      act = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_start, mc_err, busy};
      n_total++;
      if (act === e.v && stall_cnt === e.sc && flush_cnt === e.fc) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got out=%b sc=%0d fc=%0d, expected out=%b sc=%0d fc=%0d",
                 e.name, act, stall_cnt, flush_cnt, e.v, e.sc, e.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; id_instr = 32'd0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_mc_req = 1'b0; br_taken = 1'b0; mc_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset: outputs quiet even with requests present.
    step(1'b1, ADD_655, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, NONE, "reset_quiet");
    // Load-use via rs1: exactly one bubble.
    step(1'b0, ADD_655, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU,   "lu_rs1");
    step(1'b0, ADD_655, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, NONE, "lu_released");
    step(1'b0, LUI_5,   5'd5, 1'b1, 1'b0, 1'b0, 1'b0, NONE, "lui_no_use");
    step(1'b0, ADD_601, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NONE, "x0_no_hz");
    step(1'b0, SW_5,    5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU,   "lu_rs2_store");
    step(1'b0, JAL_F5,  5'd5, 1'b1, 1'b0, 1'b0, 1'b0, NONE, "jal_no_use");
    step(1'b0, ADD_655, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NONE, "not_load");
    // Branch outranks load-use.
    step(1'b0, ADD_655, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, BR,   "br_over_lu");
    // Multi-cycle, done 5 cycles after start; branch ignored in both states.
    step(1'b0, ADD_655, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, MCS,  "mc_start");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MCW,  "mc_wait1");
    step(1'b0, ADD_655, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, MCW,  "mc_wait2_ign");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MCW,  "mc_wait3");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MCW,  "mc_wait4");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BSY,  "mc_done");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, "busy_fell");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NONE, "done_in_run");
    // Minimum occupancy: done right after start.
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MCS,  "mc_min_start");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BSY,  "mc_min_done");
    // Done coinciding with the timeout cycle: no error.
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MCS,  "mc_edge_start");
    for (int i = 0; i < 7; i++)
      step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MCW, "mc_edge_wait");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BSY,  "mc_edge_done");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, "mc_edge_no_err");
    // Timeout: start + 7 wait cycles, then forced release and sticky error.
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MCS,  "to_start");
    for (int i = 0; i < 7; i++)
      step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MCW, "to_wait");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, BSY,  "to_release");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ERR,  "to_err_set");
    step(1'b0, ADD_655, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU | ERR, "err_sticky_lu");
    // Reset in the middle of MC_WAIT.
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MCS | ERR, "rst_mc_start");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MCW | ERR, "rst_mc_wait");
    step(1'b1, ADD_601, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BSY | ERR, "rst_mid_wait");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, "after_rst");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BR,   "br_after_rst");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MCS,  "mc_after_rst");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BSY,  "mc_after_rst_done");
    step(1'b0, ADD_601, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, "final_idle");
    repeat (3) @(posedge clk);
    n_total++;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end else begin
      n_pass++;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
